// File: rtl/fsm_pulse_sched_if.sv
// Bundle of the requester/counter-facing signals of fsm_pulse_sched.
// The slave modport is the scheduler's view; the master modport belongs to
// whoever drives the requests and returns the counter state.
interface fsm_pulse_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [1:0]      cnt_state;
  logic [NREQ-1:0] gnt;
  logic            xin_out;
  logic            busy;
  logic            done;
  logic            aborted;
  logic            err;

  modport master (
    output req, cnt_state,
    input  gnt, xin_out, busy, done, aborted, err
  );

  modport slave (
    input  req, cnt_state,
    output gnt, xin_out, busy, done, aborted, err
  );
endinterface

// File: rtl/fsm_pulse_sched.sv
// Shares one modulo-4 pulse-counter FSM between NREQ requesters. Each grant
// drives BURST single-cycle xin pulses for the owner, then waits GAP idle
// cycles before re-arbitrating. A 2-bit shadow follows the counter and any
// divergence sets a sticky err flag.
// Build option: define FSM_PULSE_SCHED_PRIO_EN for fixed-priority
// arbitration (lowest index wins); default is round-robin.
module fsm_pulse_sched #(
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  parameter int GAP   = 1
) (
  input logic              clk,
  input logic              reset,
  fsm_pulse_sched_if.slave sched
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] BURST_C = 4'(BURST);
  localparam logic [2:0] GAP_C   = 3'(GAP);

  typedef enum logic [1:0] {IDLE, RUN, FIN, GAPW} state_e;
  typedef logic [NREQ-1:0] req_t;

  state_e           state_q, state_d;
  req_t             gnt_q, gnt_d;
  logic             xin_q, xin_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_q, err_d;
  logic [3:0]       pulse_cnt_q, pulse_cnt_d;
  logic [2:0]       gap_cnt_q, gap_cnt_d;
  logic [1:0]       shadow_q, shadow_d;

  logic             found;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] idx;
  logic             owner_req;

`ifndef FSM_PULSE_SCHED_PRIO_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // The owner still wants the counter while its request bit stays high.
  assign owner_req = |(sched.req & gnt_q);

  // Pick the next winner among the active requests.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
`ifdef FSM_PULSE_SCHED_PRIO_EN
    // Scan downward so the lowest set index is the last one written.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PTR_W'(i);
      if (sched.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`else
    // Scan the rotated order backwards so the nearest bit after rr_ptr wins.
    for (int i = NREQ; i >= 1; i--) begin
      idx = PTR_W'((int'(rr_ptr_q) + i) % NREQ);
      if (sched.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
`endif
  end

  // Next-state and registered-output logic of the grant FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    gnt_d       = gnt_q;
    xin_d       = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shadow_d    = shadow_q + {1'b0, xin_q};
    err_d       = err_q | (sched.cnt_state != shadow_q);
`ifndef FSM_PULSE_SCHED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = req_t'(1) << winner;
          pulse_cnt_d = '0;
          state_d     = RUN;
`ifndef FSM_PULSE_SCHED_PRIO_EN
          rr_ptr_d    = winner;
`endif
        end
      end
      RUN: begin
        // Completion takes precedence over an abort on the same edge.
        if (pulse_cnt_q == BURST_C) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (!owner_req) begin
          aborted_d = 1'b1;
          state_d   = FIN;
          done_d    = 1'b1;
        end else begin
          xin_d       = 1'b1;
          pulse_cnt_d = pulse_cnt_q + 4'd1;
        end
      end
      FIN: begin
        gnt_d = '0;
        if (GAP == 0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = GAP_C;
          state_d   = GAPW;
        end
      end
      GAPW: begin
        if (gap_cnt_q <= 3'd1) state_d = IDLE;
        else                   gap_cnt_d = gap_cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      xin_q       <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      shadow_q    <= 2'b00;
`ifndef FSM_PULSE_SCHED_PRIO_EN
      rr_ptr_q    <= PTR_W'(NREQ - 1);
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      xin_q       <= xin_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shadow_q    <= shadow_d;
`ifndef FSM_PULSE_SCHED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign sched.gnt     = gnt_q;
  assign sched.xin_out = xin_q;
  assign sched.busy    = (state_q != IDLE);
  assign sched.done    = done_q;
  assign sched.aborted = aborted_q;
  assign sched.err     = err_q;

endmodule

// File: tb/tb_fsm_pulse_sched.sv
// Directed bench for fsm_pulse_sched with a modulo-4 counter FSM on xin_out
// feeding cnt_state back. Expected values are hand-derived for NREQ=4,
// BURST=4, GAP=1; FSM_PULSE_SCHED_PRIO_EN selects the priority-build values.
module tb_fsm_pulse_sched;

  localparam int NREQ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] ctr_q;
  logic [1:0] corrupt = 2'b00;

  int checks = 0;
  int errors = 0;

  fsm_pulse_sched_if #(.NREQ(NREQ)) sif ();

  fsm_pulse_sched #(.NREQ(NREQ), .BURST(4), .GAP(1)) dut (
    .clk   (clk),
    .reset (reset),
    .sched (sif.slave)
  );

  always #5 clk = ~clk;

  // The shared counter: advances on every edge that samples xin high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          ctr_q <= 2'b00;
    else if (sif.xin_out) ctr_q <= ctr_q + 2'd1;
  end

  // corrupt lets the bench inject a wrong counter state on purpose.
  assign sif.cnt_state = ctr_q ^ corrupt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    sif.req = '0;
    corrupt = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits for gnt to fall (if high) and then rise; counts negedges.
  task automatic next_grant(output int cycles, output logic [NREQ-1:0] g);
    cycles = 0;
    while (sif.gnt != '0 && cycles < 40) begin @(negedge clk); cycles++; end
    while (sif.gnt == '0 && cycles < 40) begin @(negedge clk); cycles++; end
    g = sif.gnt;
  endtask

  // Waits for done, counting negedges and xin-high samples on the way.
  task automatic wait_done(output int cycles, output int pulses);
    cycles = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (sif.xin_out) pulses++;
    end while (!sif.done && cycles < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pul;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] exp_seq [4];

    sif.req = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(sif.gnt), 32'h0);
    check("rst_xin", 32'(sif.xin_out), 32'h0);
    check("rst_busy", 32'(sif.busy), 32'h0);
    check("rst_done", 32'(sif.done), 32'h0);
    check("rst_abort", 32'(sif.aborted), 32'h0);
    check("rst_err", 32'(sif.err), 32'h0);

    // Single full burst for requester 0
    reset   = 1'b1;
    sif.req = 4'b0001;
    next_grant(cyc, g);
    check("t1_gnt", 32'(g), 32'h1);
    check("t1_lat", 32'(cyc), 32'd1);
    check("t1_busy", 32'(sif.busy), 32'h1);
    check("t1_xin0", 32'(sif.xin_out), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_xin", 32'(sif.xin_out), 32'h1);
      check("t1_ctr", 32'(ctr_q), 32'(k));
    end
    @(negedge clk);
    check("t1_xin_end", 32'(sif.xin_out), 32'h0);
    check("t1_done", 32'(sif.done), 32'h1);
    check("t1_abort", 32'(sif.aborted), 32'h0);
    check("t1_ctr_wrap", 32'(ctr_q), 32'h0);
    check("t1_err", 32'(sif.err), 32'h0);
    sif.req = '0;

    // All four requesting: grant order and spacing
`ifdef FSM_PULSE_SCHED_PRIO_EN
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    do_reset();
    sif.req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      next_grant(cyc, g);
      check("t2_gnt", 32'(g), 32'(exp_seq[n]));
      check("t2_space", 32'(cyc), (n == 0) ? 32'd1 : 32'd8);
    end
    wait_done(cyc, pul);
    check("t2_pulses", 32'(pul), 32'd4);
    check("t2_err", 32'(sif.err), 32'h0);
    sif.req = '0;

    // Abort after two pulses, then resume from counter state 2
    do_reset();
    sif.req = 4'b0010;
    next_grant(cyc, g);
    check("t3_gnt", 32'(g), 32'h2);
    repeat (2) @(negedge clk);
    check("t3_xin", 32'(sif.xin_out), 32'h1);
    sif.req = '0;
    @(negedge clk);
    check("t3_xin_low", 32'(sif.xin_out), 32'h0);
    check("t3_done", 32'(sif.done), 32'h1);
    check("t3_abort", 32'(sif.aborted), 32'h1);
    check("t3_ctr", 32'(ctr_q), 32'h2);
    check("t3_err", 32'(sif.err), 32'h0);
    sif.req = 4'b0010;
    next_grant(cyc, g);
    check("t3_regnt", 32'(g), 32'h2);
    check("t3_regnt_lat", 32'(cyc), 32'd3);
    wait_done(cyc, pul);
    check("t3_cyc", 32'(cyc), 32'd5);
    check("t3_pulses", 32'(pul), 32'd4);
    check("t3_ctr_end", 32'(ctr_q), 32'h2);
    check("t3_abort2", 32'(sif.aborted), 32'h0);
    check("t3_err2", 32'(sif.err), 32'h0);
    sif.req = '0;

    // Counter disagreement sets a sticky error
    do_reset();
    sif.req = 4'b0001;
    next_grant(cyc, g);
    @(negedge clk);
    check("t4_err_pre", 32'(sif.err), 32'h0);
    corrupt = 2'b01;
    @(negedge clk);
    corrupt = 2'b00;
    check("t4_err_set", 32'(sif.err), 32'h1);
    sif.req = '0;
    wait_done(cyc, pul);
    repeat (5) @(negedge clk);
    check("t4_idle", 32'(sif.busy), 32'h0);
    check("t4_err_hold", 32'(sif.err), 32'h1);
    reset = 1'b0;
    #1;
    check("t4_err_clr", 32'(sif.err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-burst after three pulses
    do_reset();
    sif.req = 4'b0001;
    next_grant(cyc, g);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_xin", 32'(sif.xin_out), 32'h1);
    end
    #2;
    reset = 1'b0;
    #1;
    check("t5_gnt", 32'(sif.gnt), 32'h0);
    check("t5_xin_rst", 32'(sif.xin_out), 32'h0);
    check("t5_busy", 32'(sif.busy), 32'h0);
    check("t5_done", 32'(sif.done), 32'h0);
    @(negedge clk);
    check("t5_done2", 32'(sif.done), 32'h0);
    reset   = 1'b1;
    sif.req = 4'b0110;
    next_grant(cyc, g);
    check("t5_first", 32'(g), 32'h2);
    check("t5_lat", 32'(cyc), 32'd1);
    sif.req = '0;

    // Simultaneous req[0] and req[2] with rr_ptr at 0
    do_reset();
    sif.req = 4'b0001;
    next_grant(cyc, g);
    wait_done(cyc, pul);
    check("t6_pulses", 32'(pul), 32'd4);
    sif.req = '0;
    repeat (3) @(negedge clk);
    check("t6_idle", 32'(sif.busy), 32'h0);
    sif.req = 4'b0101;
    next_grant(cyc, g);
`ifdef FSM_PULSE_SCHED_PRIO_EN
    check("t6_gnt", 32'(g), 32'h1);
`else
    check("t6_gnt", 32'(g), 32'h4);
`endif
    check("t6_lat", 32'(cyc), 32'd1);
    sif.req = '0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
